// File: rtl/cursor_tile_walker.sv
// Serpentine 4x4 tile sequencer feeding the cursor/palette row-offset stage.
// Every output is registered on the rising edge so it is stable at the downstream falling-edge sample.
module cursor_tile_walker #(
  parameter int TILE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] in_y,
  output logic       loady,
  output logic       plus,
  output logic       sum,
  output logic [2:0] C,
  output logic [1:0] col,
  output logic       wr_req,
  input  logic       wr_ack,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] LAST = 2'(TILE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    STEP  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state_reg, state_next;
  logic       loady_reg, loady_next;
  logic       plus_reg, plus_next;
  logic       wr_req_reg, wr_req_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       sum_reg, sum_next;
  logic [1:0] c_reg, c_next;
  logic [1:0] col_reg, col_next;

  // in_y goes straight to the downstream stage; this block never stores it.
  logic unused_in_y;
  assign unused_in_y = ^in_y;

  always_comb begin
    state_next  = state_reg;
    loady_next  = 1'b0;
    plus_next   = 1'b0;
    wr_req_next = 1'b0;
    done_next   = 1'b0;
    sum_next    = sum_reg;
    c_next      = c_reg;
    col_next    = col_reg;

    if (abort) begin
      // Abort beats start in IDLE and beats wr_ack / advance everywhere else.
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = LOAD;
            loady_next = 1'b1;
            c_next     = 2'd0;
            col_next   = 2'd0;
            sum_next   = 1'b1;
          end
        end
        LOAD: begin
          state_next = STEP;
          plus_next  = 1'b1;
        end
        STEP: begin
          state_next  = WRITE;
          wr_req_next = 1'b1;
        end
        WRITE: begin
          if (!wr_ack) begin
            wr_req_next = 1'b1;
          end else if (c_reg != LAST) begin
            state_next = STEP;
            plus_next  = 1'b1;
            c_next     = c_reg + 2'd1;
          end else if (col_reg != LAST) begin
            state_next = STEP;
            plus_next  = 1'b1;
            c_next     = 2'd0;
            col_next   = col_reg + 2'd1;
            sum_next   = ~sum_reg;
          end else begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      loady_reg  <= 1'b0;
      plus_reg   <= 1'b0;
      wr_req_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      sum_reg    <= 1'b1;
      c_reg      <= 2'd0;
      col_reg    <= 2'd0;
    end else begin
      state_reg  <= state_next;
      loady_reg  <= loady_next;
      plus_reg   <= plus_next;
      wr_req_reg <= wr_req_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      sum_reg    <= sum_next;
      c_reg      <= c_next;
      col_reg    <= col_next;
    end
  end

  assign loady  = loady_reg;
  assign plus   = plus_reg;
  assign wr_req = wr_req_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign sum    = sum_reg;
  assign C      = {1'b0, c_reg};
  assign col    = col_reg;

endmodule

// File: tb/tb_cursor_tile_walker.sv
// Directed + randomized bench for cursor_tile_walker; a cell-list model gives the
// expected serpentine row offsets, columns and walk lengths.
module tb_cursor_tile_walker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [5:0] in_y;
  logic       loady;
  logic       plus;
  logic       sum;
  logic [2:0] C;
  logic [1:0] col;
  logic       wr_req;
  logic       wr_ack;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int stalls [16];

  cursor_tile_walker #(.TILE(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .in_y   (in_y),
    .loady  (loady),
    .plus   (plus),
    .sum    (sum),
    .C      (C),
    .col    (col),
    .wr_req (wr_req),
    .wr_ack (wr_ack),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: cell k sits in column k/4; even columns run rows 0..3, odd columns 3..0.
  function automatic int ref_row(input int k);
    return ((k / 4) % 2 == 0) ? (k % 4) : (3 - (k % 4));
  endfunction

  // Row the downstream stage would compute from the strobed values.
  function automatic int downstream_y(input int y, input logic s, input logic [2:0] c);
    return s ? (4 * y + int'(c)) : (4 * y + 3 - int'(c));
  endfunction

  task automatic walk(input int y, input int abort_cell, input bit busy_starts, input int exp_len);
    int  n, p, stall_left, loads, len;
    bit  fin;
    p = 0; loads = 0; len = -1; stall_left = 0; fin = 0;
    @(negedge clk);
    start = 1'b1; in_y = 6'(y); wr_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!fin) begin
      chk("loady_plus_excl", 32'(loady & plus), 32'd0);
      if (loady) begin
        loads++;
        chk("load_C", 32'(C), 32'd0);
        chk("load_col", 32'(col), 32'd0);
        chk("load_sum", 32'(sum), 32'd1);
      end
      if (plus) begin
        if (p < 16) begin
          chk("cell_C", 32'(C), 32'(p % 4));
          chk("cell_col", 32'(col), 32'(p / 4));
          chk("out_y", 32'(downstream_y(y, sum, C)), 32'(4 * y + ref_row(p)));
          stall_left = stalls[p];
        end
        p++;
      end
      wr_ack = 1'($urandom_range(0, 1));
      if (wr_req) begin
        chk("req_C", 32'(C), 32'((p - 1) % 4));
        chk("req_col", 32'(col), 32'((p - 1) / 4));
        if (p == abort_cell) begin
          abort = 1'b1; wr_ack = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_req", 32'(wr_req), 32'd0);
          chk("abort_done", 32'(done), 32'd0);
          chk("abort_plus", 32'(plus), 32'd0);
          fin = 1;
        end else if (stall_left > 0) begin
          wr_ack = 1'b0;
          stall_left--;
        end else begin
          wr_ack = 1'b1;
        end
      end
      if (!fin && done) begin
        len = n + 1;
        chk("done_busy", 32'(busy), 32'd1);
        fin = 1;
      end
      start = (busy_starts && (n == 4 || n == 19)) ? 1'b1 : 1'b0;
      if (!fin) begin
        @(negedge clk);
        n++;
        if (n > 400) begin
          chk("walk_timeout", 32'(n), 32'(exp_len));
          fin = 1;
        end
      end
    end
    start = 1'b0; wr_ack = 1'b0;
    if (abort_cell < 0) begin
      chk("walk_len", 32'(len), 32'(exp_len));
      chk("loady_count", 32'(loads), 32'd1);
      chk("plus_count", 32'(p), 32'd16);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
      end
    end
    $display("walk y=%0d abort_cell=%0d len=%0d cells=%0d", y, abort_cell, len, p);
  endtask

  initial begin
    int total;
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_y = '0; wr_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_loady", 32'(loady), 32'd0);
    chk("rst_sum", 32'(sum), 32'd1);
    chk("rst_C", 32'(C), 32'd0);
    chk("rst_col", 32'(col), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    $display("reset idle checked");

    // Full walk, no stalls, y=5.
    for (int i = 0; i < 16; i++) stalls[i] = 0;
    walk(5, -1, 1'b0, 34);
    chk("idle_hold_C", 32'(C), 32'd3);
    chk("idle_hold_col", 32'(col), 32'd3);
    chk("idle_hold_sum", 32'(sum), 32'd0);

    // Asynchronous reset while idle.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_C", 32'(C), 32'd0);
    chk("async_rst_col", 32'(col), 32'd0);
    chk("async_rst_sum", 32'(sum), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    $display("async reset idle checked");

    // Three-cycle stall on the cell C=1, col=2.
    stalls[9] = 3;
    walk(5, -1, 1'b0, 37);
    stalls[9] = 0;

    // Abort in the 7th write, then a clean walk from the start.
    walk(11, 7, 1'b0, 0);
    walk(11, -1, 1'b0, 34);

    // Start pulses while busy are ignored.
    walk(2, -1, 1'b1, 34);

    // Start and abort together in IDLE.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sa_loady", 32'(loady), 32'd0);
      chk("sa_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    $display("start+abort in idle checked");

    // Randomized stalls and rows.
    for (int r = 0; r < 4; r++) begin
      total = 34;
      for (int i = 0; i < 16; i++) begin
        stalls[i] = int'($urandom_range(0, 3));
        total += stalls[i];
      end
      walk(int'($urandom_range(0, 63)), -1, 1'b0, total);
    end

    // Asynchronous reset mid-walk.
    for (int i = 0; i < 16; i++) stalls[i] = 0;
    @(negedge clk);
    start = 1'b1; in_y = 6'd9;
    repeat (6) @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_req", 32'(wr_req), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_C", 32'(C), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_busy", 32'(busy), 32'd0);
    $display("mid-walk reset checked");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
